// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters, with registered operands and a tagged response.
// Latency: a request accepted at edge T gives rsp_valid high in cycle T+2; peak rate is one op every 2 cycles.
// Backpressure: while rsp_ready is low the response is held and req_ready stays all-zero; a new grant can overlap the rsp_ready handshake.
//
// Ports:
//   clk, rst               single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_op     packed per-requester operands/opcode, requester i at [i*W +: W]
//   alu_a/alu_b/alu_f      registered operands/opcode driven to the external ALU
//   alu_s                  ALU result
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_id/rsp_err captured result, owning requester, unsupported-opcode flag
// Optional feature macro ALU_FLAGS_EN: adds rsp_zero/rsp_neg result flags.

module alu_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int OP_W   = 5,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_f,
    input  logic [DATA_W-1:0]       alu_s,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_err
`ifdef ALU_FLAGS_EN
    ,
    output logic                    rsp_zero,
    output logic                    rsp_neg
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [OP_W-1:0] MAX_OP = OP_W'(7);

    state_t          state;
    logic [ID_W-1:0] rr_last;
    logic [ID_W-1:0] cur_id;

    logic            grant_ok;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic            xfer;
    logic            bad_op;
    logic [DATA_W-1:0] result;

    // A new grant may only be issued when nothing is in flight, or when the
    // held response is being consumed this very cycle.
    assign grant_ok = !rst && ((state == IDLE) || (state == HOLD && rsp_ready));

    // Rotating search starting just after the last accepted requester; idle
    // requesters are skipped without disturbing the rotation order.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_last) + k) % N_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_ok && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer   = grant_ok && gnt_found;
    assign bad_op = (alu_f > MAX_OP);
    assign result = bad_op ? '0 : alu_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= ID_W'(N_REQ - 1);
            cur_id    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
`ifdef ALU_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
`endif
        end else begin
            // Operands are only loaded on acceptance, so the ALU inputs stay
            // quiet while the block is idle or holding a response.
            if (xfer) begin
                alu_a   <= req_a[gnt_idx*DATA_W +: DATA_W];
                alu_b   <= req_b[gnt_idx*DATA_W +: DATA_W];
                alu_f   <= req_op[gnt_idx*OP_W +: OP_W];
                cur_id  <= gnt_idx;
                rr_last <= gnt_idx;
            end
            case (state)
                IDLE: begin
                    if (xfer) state <= EXEC;
                end
                EXEC: begin
                    rsp_data  <= result;
                    rsp_err   <= bad_op;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                    rsp_zero  <= (result == '0);
                    rsp_neg   <= result[DATA_W-1];
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    // The response is consumed either way; a back-to-back
                    // grant goes straight to EXEC with valid low for a cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= xfer ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
